// File: rtl/ctr_pkg.sv
// Shared widths, block type and FSM encoding for the AES-CTR keystream XOR stage.
package ctr_pkg;
    localparam int BLK_W = 128;
    localparam int CTR_W = 64;
    localparam int IV_W  = BLK_W - CTR_W;

    typedef logic [BLK_W-1:0] block_t;
    typedef logic [CTR_W-1:0] ctr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_KS = 2'd2,
        OUT     = 2'd3
    } state_t;
endpackage

// File: rtl/ctr_block_gen.sv
// Counter-block generator: holds iv/count and presents {iv, count} to the AES core.
// Latency: load/increment take effect on the next clock; block output is purely registered.
// Backpressure: none; the parent decides when to load or increment.
module ctr_block_gen
    import ctr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IV_W-1:0]  iv,
    input  logic             inc,
    output logic [BLK_W-1:0] block,
    output logic [CTR_W-1:0] cnt
);
    logic [IV_W-1:0]  iv_q;
    logic [CTR_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            iv_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            iv_q  <= iv;
            cnt_q <= '0;
        end else if (inc) begin
            // wraps silently modulo 2^CTR_W
            cnt_q <= cnt_q + ctr_t'(1);
        end
    end

    assign block = {iv_q, cnt_q};
    assign cnt   = cnt_q;
endmodule

// File: rtl/ctr_keystream_xor.sv
// AES-CTR decipher consumer: issues {iv,count} blocks, XORs returned keystream onto ciphertext.
// Latency: ct accepted at N -> request N+1 -> keystream N+2 -> pt_valid N+3 (ready sinks).
// Backpressure: one block in flight; ct_ready low until pt is taken. Macro CTR_WRAP_GUARD_EN adds err.
module ctr_keystream_xor
    import ctr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IV_W-1:0]  iv,
    input  logic             ct_valid,
    input  logic [BLK_W-1:0] ct_data,
    output logic             ct_ready,
    output logic             aes_req_valid,
    output logic [BLK_W-1:0] aes_req_block,
    input  logic             aes_req_ready,
    input  logic             ks_valid,
    input  logic [BLK_W-1:0] ks_data,
    output logic             pt_valid,
    output logic [BLK_W-1:0] pt_data,
    input  logic             pt_ready,
    output logic [CTR_W-1:0] blk_count,
    output logic             busy
`ifdef CTR_WRAP_GUARD_EN
    ,
    output logic             err
`endif
);
    state_t           state, state_n;
    logic             loaded;
    logic             err_q;
    logic [BLK_W-1:0] ct_q;
    logic             load;
    logic             ct_fire;
    logic             ks_take;

    assign load    = start && (state == IDLE);
    assign ct_fire = ct_valid && ct_ready;
    assign ks_take = ks_valid && (state == WAIT_KS);

    ctr_block_gen u_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .iv    (iv),
        .inc   (ks_take),
        .block (aes_req_block),
        .cnt   (blk_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ct_fire)       state_n = REQ;
            REQ:     if (aes_req_ready) state_n = WAIT_KS;
            WAIT_KS: if (ks_valid)      state_n = OUT;
            OUT:     if (pt_ready)      state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loaded  <= 1'b0;
            ct_q    <= '0;
            pt_data <= '0;
        end else begin
            if (load)    loaded  <= 1'b1;
            if (ct_fire) ct_q    <= ct_data;
            if (ks_take) pt_data <= ct_q ^ ks_data;
        end
    end

`ifdef CTR_WRAP_GUARD_EN
    // flag the block that consumed the last counter value; only a new start clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (load) begin
            err_q <= 1'b0;
        end else if (ks_take && (&blk_count)) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err_q = 1'b0;
`endif

    assign ct_ready      = (state == IDLE) && loaded && !err_q;
    assign aes_req_valid = (state == REQ);
    assign pt_valid      = (state == OUT);
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_ctr_keystream_xor.sv
// Scoreboard bench for ctr_keystream_xor: model predicts request blocks and plaintext per message.
module tb_ctr_keystream_xor;
    import ctr_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [63:0]  iv;
    logic         ct_valid;
    logic [127:0] ct_data;
    logic         ct_ready;
    logic         aes_req_valid;
    logic [127:0] aes_req_block;
    logic         aes_req_ready;
    logic         ks_valid;
    logic [127:0] ks_data;
    logic         pt_valid;
    logic [127:0] pt_data;
    logic         pt_ready;
    logic [63:0]  blk_count;
    logic         busy;
`ifdef CTR_WRAP_GUARD_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    ctr_keystream_xor dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .iv            (iv),
        .ct_valid      (ct_valid),
        .ct_data       (ct_data),
        .ct_ready      (ct_ready),
        .aes_req_valid (aes_req_valid),
        .aes_req_block (aes_req_block),
        .aes_req_ready (aes_req_ready),
        .ks_valid      (ks_valid),
        .ks_data       (ks_data),
        .pt_valid      (pt_valid),
        .pt_data       (pt_data),
        .pt_ready      (pt_ready),
        .blk_count     (blk_count),
        .busy          (busy)
`ifdef CTR_WRAP_GUARD_EN
        ,
        .err           (err)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // reference model: the message's iv, next counter value, outstanding expectations
    logic [63:0]  m_iv  = '0;
    logic [63:0]  m_cnt = '0;
    logic [127:0] req_q[$];
    logic [127:0] pt_q[$];
    int           acc_q[$];

    // environment knobs: 0 = always ready, 1 = random, 2 = held low
    int           aes_mode = 0;
    int           pt_mode  = 0;
    bit           ks_rand  = 1'b0;
    int           ks_fix   = 0;
    bit           lat_chk  = 1'b0;
    bit           ks_pend  = 1'b0;
    logic [127:0] ks_blk   = '0;
    int           ks_dly   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void fail(string name);
        n_checks++;
        $display("FAIL %s: wait bound expired", name);
    endfunction

    // stand-in for the AES core: any fixed bijective-looking scramble of the counter block
    function automatic logic [127:0] fake_aes(logic [127:0] b);
        logic [127:0] k;
        k = 128'h5A5A_C3C3_0F0F_9669_A5A5_3C3C_F0F0_6996;
        return {b[63:0], b[127:64]} ^ {b[6:0], b[127:7]} ^ k;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // AES responder, ready generators and output monitor
    initial begin
        logic [127:0] e;
        int a;
        forever begin
            @(posedge clk);
            #2;
            ks_valid = 1'b0;
            if (ks_pend) begin
                if (ks_dly == 0) begin
                    ks_valid = 1'b1;
                    ks_data  = fake_aes(ks_blk);
                    ks_pend  = 1'b0;
                end else begin
                    ks_dly--;
                end
            end
            aes_req_ready = (aes_mode == 0) ? 1'b1 : (aes_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            pt_ready      = (pt_mode == 0)  ? 1'b1 : (pt_mode == 1)  ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (aes_req_valid && aes_req_ready) begin
                if (req_q.size() == 0) fail("req_unexpected");
                else chk("req_block", aes_req_block, req_q.pop_front());
                ks_pend = 1'b1;
                ks_blk  = aes_req_block;
                ks_dly  = ks_rand ? int'($urandom_range(0, 3)) : ks_fix;
            end
            if (pt_valid && pt_ready) begin
                if (pt_q.size() == 0) begin
                    fail("pt_unexpected");
                end else begin
                    e = pt_q.pop_front();
                    a = acc_q.pop_front();
                    chk("pt_data", pt_data, e);
                    if (lat_chk) chk("pt_latency", 128'(cyc - a), 128'd3);
                end
            end
        end
    end

    task automatic send_ct(input logic [127:0] d);
        logic [127:0] blk;
        bit ok;
        ok       = 1'b0;
        ct_valid = 1'b1;
        ct_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ct_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            blk = {m_iv, m_cnt};
            req_q.push_back(blk);
            pt_q.push_back(d ^ fake_aes(blk));
            acc_q.push_back(cyc);
            m_cnt++;
        end else begin
            fail("ct_accept");
        end
        @(posedge clk);
        #1;
        ct_valid = 1'b0;
    endtask

    // a start is honoured only when no block is outstanding
    task automatic do_start(input logic [63:0] v);
        start = 1'b1;
        iv    = v;
        if (pt_q.size() == 0) begin
            m_iv  = v;
            m_cnt = '0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pt_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; iv = '0; ct_valid = 1'b0; ct_data = '0;
        aes_req_ready = 1'b0; ks_valid = 1'b0; ks_data = '0; pt_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_req_valid", 128'(aes_req_valid), 128'd0);
        chk("rst_pt_valid", 128'(pt_valid), 128'd0);
        chk("rst_ct_ready", 128'(ct_ready), 128'd0);
        chk("rst_pt_data", pt_data, 128'd0);
        chk("rst_req_block", aes_req_block, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("unloaded_ct_ready", 128'(ct_ready), 128'd0);
        @(posedge clk);
        #1;

        // first message with a known iv
        do_start(64'h0123456789ABCDEF);
        send_ct(rnd128());
        drain();
        chk("first_blk_count", 128'(blk_count), 128'(m_cnt));

        // four back-to-back blocks, fixed latency
        do_start({$urandom, $urandom});
        lat_chk = 1'b1;
        for (int i = 0; i < 4; i++) send_ct(rnd128());
        drain();
        lat_chk = 1'b0;
        chk("b2b_blk_count", 128'(blk_count), 128'(m_cnt));

        // output stall
        pt_mode = 2;
        send_ct(rnd128());
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pt_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("hold_pt_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_pt_valid", 128'(pt_valid), 128'd1);
            chk("hold_pt_data", pt_data, (pt_q.size() != 0) ? pt_q[0] : 128'd0);
            chk("hold_ct_ready", 128'(ct_ready), 128'd0);
            chk("hold_req_valid", 128'(aes_req_valid), 128'd0);
        end
        @(posedge clk);
        #1;
        pt_mode = 0;
        drain();

        // start while waiting for keystream is ignored
        ks_fix = 3;
        send_ct(rnd128());
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy && !aes_req_valid && !pt_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("reach_wait_ks");
        @(posedge clk);
        #1;
        do_start({$urandom, $urandom});
        @(negedge clk);
        chk("ignored_start_cnt", 128'(blk_count), 128'(m_cnt - 64'd1));
        @(posedge clk);
        #1;
        ks_fix = 0;
        drain();
        send_ct(rnd128());
        drain();
        chk("after_ignored_cnt", 128'(blk_count), 128'(m_cnt));

        // counter wrap
        force dut.u_gen.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.u_gen.cnt_q;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("wrap_preload", 128'(blk_count), 128'(m_cnt));
        @(posedge clk);
        #1;
        send_ct(rnd128());
        drain();
        chk("wrap_cnt", 128'(blk_count), 128'd0);
`ifdef CTR_WRAP_GUARD_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wrap_err", 128'(err), 128'd1);
            chk("wrap_ct_ready", 128'(ct_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        do_start({$urandom, $urandom});
        @(negedge clk);
        chk("restart_err", 128'(err), 128'd0);
        chk("restart_ct_ready", 128'(ct_ready), 128'd1);
        @(posedge clk);
        #1;
`else
        @(negedge clk);
        chk("wrap_ct_ready", 128'(ct_ready), 128'd1);
        @(posedge clk);
        #1;
        send_ct(rnd128());
        drain();
        chk("post_wrap_cnt", 128'(blk_count), 128'(m_cnt));
`endif

        // reset while a request is pending
        aes_mode = 2;
        send_ct(rnd128());
        @(negedge clk);
        chk("in_req", 128'(aes_req_valid), 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        aes_mode = 0;
        req_q.delete();
        pt_q.delete();
        acc_q.delete();
        ks_pend = 1'b0;
        m_iv = '0;
        m_cnt = '0;
        @(negedge clk);
        chk("midrst_req_valid", 128'(aes_req_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_cnt", 128'(blk_count), 128'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_ct_ready", 128'(ct_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        do_start({$urandom, $urandom});

        // randomized traffic with random handshakes and occasional restarts
        aes_mode = 1;
        pt_mode  = 1;
        ks_rand  = 1'b1;
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                drain();
                do_start({$urandom, $urandom});
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_ct(rnd128());
        end
        drain();
        chk("rand_blk_count", 128'(blk_count), 128'(m_cnt));
        chk("req_q_empty", 128'(req_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
